// File: rtl/key_repeat.sv
// Key press/release pulse generator with typematic auto-repeat for the maze controller.
// Optional auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise press/release edges only.
module key_repeat #(
   parameter int N     = 4,
   parameter int DELAY = 2000,
   parameter int RATE  = 500
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic [N-1:0] key_n,
   output logic [N-1:0] key_pulse,
   output logic [N-1:0] key_rel,
   output logic         rpt_active
);

   if (DELAY < 2 || DELAY > 24'hFFFFFF || RATE < 2 || RATE > 24'hFFFFFF) begin : g_bad_timing
      $error("key_repeat: DELAY and RATE must lie in 2..2^24-1");
   end

   logic [N-1:0] prev_q;
   logic [N-1:0] pulse_q, pulse_d;
   logic [N-1:0] rel_q;
   logic [N-1:0] press;
   logic [N-1:0] release_e;

   assign press     = prev_q & ~key_n;
   assign release_e = ~prev_q & key_n;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         prev_q  <= '1;
         pulse_q <= '0;
         rel_q   <= '0;
      end else begin
         prev_q  <= key_n;
         pulse_q <= pulse_d;
         rel_q   <= release_e;
      end
   end

   assign key_pulse = pulse_q;
   assign key_rel   = rel_q;

`ifdef KEY_REPEAT_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_REPEAT
   } state_t;

   localparam logic [23:0] DLY_END  = 24'(DELAY - 1);
   localparam logic [23:0] RATE_END = 24'(RATE - 1);

   state_t       state_q, state_d;
   logic [23:0]  cnt_q, cnt_d;
   logic         rpt_q, rpt_d;
   logic         fire;
   logic [N-1:0] held;
   logic [N-1:0] target;
   logic         change;

   assign held   = ~key_n;
   // Isolates the lowest set bit: the lowest-index held key owns the repeat.
   assign target = held & (~held + N'(1));
   assign change = (key_n != prev_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      if (change) begin
         cnt_d   = '0;
         state_d = (|held) ? S_DELAY : S_IDLE;
      end else begin
         case (state_q)
            S_DELAY: begin
               if (cnt_q == DLY_END) begin
                  fire    = 1'b1;
                  state_d = S_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 24'd1;
               end
            end
            S_REPEAT: begin
               if (cnt_q == RATE_END) begin
                  fire  = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 24'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      pulse_d = press | (fire ? target : '0);
      rpt_d   = (state_d == S_REPEAT);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rpt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rpt_q   <= rpt_d;
      end
   end

   assign rpt_active = rpt_q;
`else
   always_comb begin
      pulse_d = press;
   end

   assign rpt_active = 1'b0;
`endif

endmodule

// File: tb/tb_key_repeat.sv
// Directed scoreboard bench for key_repeat (N=4, DELAY=4, RATE=3); follows KEY_REPEAT_EN like the RTL.
module tb_key_repeat;
   localparam int N   = 4;
   localparam int DLY = 4;
   localparam int RT  = 3;
`ifdef KEY_REPEAT_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         nrst;
   logic [N-1:0] key_n;
   logic [N-1:0] key_pulse;
   logic [N-1:0] key_rel;
   logic         rpt_active;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string        tag;
      logic [N-1:0] p;
      logic [N-1:0] r;
      logic         a;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   key_repeat #(.N(N), .DELAY(DLY), .RATE(RT)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .key_n      (key_n),
      .key_pulse  (key_pulse),
      .key_rel    (key_rel),
      .rpt_active (rpt_active)
   );

   task automatic compare(input exp_t e);
      total++;
      assert (key_pulse === e.p) else begin
         bad++;
         $error("FAIL %s key_pulse got=%b exp=%b", e.tag, key_pulse, e.p);
      end
      total++;
      assert (key_rel === e.r) else begin
         bad++;
         $error("FAIL %s key_rel got=%b exp=%b", e.tag, key_rel, e.r);
      end
      total++;
      assert (rpt_active === e.a) else begin
         bad++;
         $error("FAIL %s rpt_active got=%b exp=%b", e.tag, rpt_active, e.a);
      end
   endtask

   // Drive key_n, expect the result registered at the next rising edge.
   task automatic step(input logic [N-1:0] k, input string tag,
                       input logic [N-1:0] p, input logic [N-1:0] r, input logic a);
      exp_t e;
      key_n = k;
      sb.push_back('{tag, p, r, a});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare(e);
   endtask

   // First cycle of a hold carries the edge pulses; later cycles follow the repeat schedule.
   task automatic hold(input logic [N-1:0] k, input logic [N-1:0] p0, input logic [N-1:0] r0,
                       input logic [N-1:0] tgt, input int ncyc, input string tag);
      logic rep;
      logic act;
      step(k, {tag, "_edge"}, p0, r0, 1'b0);
      for (int c = 1; c < ncyc; c++) begin
         act = EN && (c >= DLY);
         rep = act && (((c - DLY) % RT) == 0);
         step(k, $sformatf("%s_c%0d", tag, c), rep ? tgt : 4'b0000, 4'b0000, act);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(4'b1111, $sformatf("%s_%0d", tag, i), 4'b0000, 4'b0000, 1'b0);
   endtask

   initial begin
      exp_t e;
      nrst  = 1'b0;
      key_n = 4'b1111;
      #1;
      e = '{"reset", 4'b0000, 4'b0000, 1'b0};
      compare(e);
      repeat (2) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;

      idle(20, "idle");

      // key 0 held 15 cycles: pulses at hold cycles 0,4,7,10,13
      hold(4'b1110, 4'b0001, 4'b0000, 4'b0001, 15, "k0");
      step(4'b1111, "k0_rel", 4'b0000, 4'b0001, 1'b0);
      idle(3, "k0_after");

      // short tap on key 2: no repeat
      hold(4'b1011, 4'b0100, 4'b0000, 4'b0100, 3, "k2");
      step(4'b1111, "k2_rel", 4'b0000, 4'b0100, 1'b0);
      idle(2, "k2_after");

      // key 3 held, key 1 added at +6: timer restarts, repeat moves to bit 1
      hold(4'b0111, 4'b1000, 4'b0000, 4'b1000, 6, "k3");
      hold(4'b0101, 4'b0010, 4'b0000, 4'b0010, 8, "k31");
      // drop key 1 and keep key 3: release pulse plus restart on key 3
      hold(4'b0111, 4'b0000, 4'b0010, 4'b1000, 5, "k3b");
      // release key 3 and press key 0 together
      hold(4'b1110, 4'b0001, 4'b1000, 4'b0001, 5, "swap");
      step(4'b1111, "swap_rel", 4'b0000, 4'b0001, 1'b0);
      idle(2, "swap_after");

      // reset while repeating, key kept held through reset
      hold(4'b1110, 4'b0001, 4'b0000, 4'b0001, 6, "rst_hold");
      #2;
      nrst = 1'b0;
      #1;
      e = '{"async_clr", 4'b0000, 4'b0000, 1'b0};
      compare(e);
      @(posedge clk);
      #1;
      e = '{"in_reset", 4'b0000, 4'b0000, 1'b0};
      compare(e);
      @(negedge clk);
      nrst = 1'b1;
      hold(4'b1110, 4'b0001, 4'b0000, 4'b0001, 5, "post_rst");
      step(4'b1111, "post_rst_rel", 4'b0000, 4'b0001, 1'b0);
      idle(2, "post_rst_after");

      // long hold: exactly one pulse when repeat is not built
      hold(4'b1110, 4'b0001, 4'b0000, 4'b0001, 20, "long");
      step(4'b1111, "long_rel", 4'b0000, 4'b0001, 1'b0);
      idle(3, "end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/key_repeat.md
# key_repeat

Key event generator and auto-repeater on the consumer side of the key debouncer. It takes the debounced active-low key levels and produces one-cycle press and release pulses for the game logic. While a key is held, it also produces typematic repeat pulses: a first repeat after a hold delay, then one every repeat period. It sits between the debouncer outputs and the maze movement controller, so a held direction key keeps stepping the player.

## Interface
- N, 4: number of keys (up/down/left/right)
- DELAY, 2000: hold cycles before first repeat; legal range 2..2^24-1
- RATE, 500: cycles between subsequent repeats; legal range 2..2^24-1
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low; clock clk
- key_n  input  N  debounced key levels, active-low (1 = released), synchronous to clk
- key_pulse  output  N  one-cycle pulse per press event or repeat event, per key
- key_rel  output  N  one-cycle pulse per release event, per key
- rpt_active  output  1  high while in REPEAT state

## Operation
- prev_n register holds key_n from the previous cycle. Reset value is all ones, so keys are released at reset.
- Press edge: prev_n[i]=1 and key_n[i]=0. Release edge: prev_n[i]=0 and key_n[i]=1. Edges are detected independently per key.
- held = ~key_n. Repeat target = lowest-index set bit of held.
- FSM states are IDLE, DELAY and REPEAT. A 24-bit counter cnt is shared by DELAY and REPEAT.
- Change means key_n != prev_n, in any bit.
- Transitions are evaluated in this priority order:
  - Change with held != 0: go to DELAY, cnt=0 (from any state).
  - Change with held == 0: go to IDLE, cnt=0.
  - DELAY, no change, cnt==DELAY-1: fire repeat, go to REPEAT, cnt=0.
  - REPEAT, no change, cnt==RATE-1: fire repeat, cnt=0.
  - Otherwise, in DELAY or REPEAT: cnt=cnt+1.
  - Otherwise, in IDLE: hold cnt=0.
- A repeat sets the key_pulse bit of the repeat target only.
- key_pulse = press edges OR repeat. A press and a repeat can never coincide, because a press is a change and restarts the timer.
- Simultaneous press and release in the same cycle: both pulses fire, and the timer restarts if any key is still held.
- Adding or removing a second held key restarts DELAY. The repeat target is recomputed every cycle from the current held value.
- All-ones key_n with no change: stays in IDLE, no pulses.

## Timing
- All outputs are registered. Reset values: key_pulse=0, key_rel=0, rpt_active=0, prev_n=all ones, state=IDLE, cnt=0.
- Edge latency: key_n change sampled at clock edge k gives the pulse high for exactly the one cycle after edge k.
- Repeat schedule for an uninterrupted hold first sampled at edge k:
  - repeat pulses are registered at edges k+DELAY, k+DELAY+RATE, k+DELAY+2*RATE, ...
  - rpt_active rises at edge k+DELAY.
- Release sampled at edge r: key_rel pulses after edge r and the FSM is IDLE from edge r. No repeat is registered at edge r, even if it was due.
- Reset mid-operation: all outputs clear immediately (asynchronous). After reset, a key already held is seen as a new press on the first clock edge.
- No handshake exists: pulses are fire-and-forget, and the consumer samples every cycle.

## Configuration
- KEY_REPEAT_EN defined: FSM, counter and repeat logic are present as described above.
- KEY_REPEAT_EN undefined:
  - FSM and cnt are not built.
  - key_pulse carries press edges only.
  - key_rel is unchanged.
  - rpt_active is tied to 0.
  - DELAY and RATE are ignored.

## Test plan
All scenarios use N=4, DELAY=4, RATE=3.
- Reset with key_n=4'b1111, then idle for 20 cycles -> all outputs 0 throughout, FSM IDLE.
- key_n[0] low from edge 10, held for 15 cycles, then released ->
  - key_pulse=4'b0001 after edges 10, 14, 17, 20, 23.
  - rpt_active high from edge 14.
  - key_rel=4'b0001 one cycle after the release edge.
- key_n[2] held 3 cycles then released -> one key_pulse=4'b0100, one key_rel=4'b0100, no repeat, rpt_active stays 0.
- key_n[3] held, then key_n[1] pressed at edge +6 ->
  - key_pulse=4'b0010 at the press.
  - Timer restarts: the next repeat is 4 cycles later, on bit 1 (the lowest-index held key).
- Hold key_n[0] into REPEAT, assert nrst low mid-hold, then release nrst ->
  - Outputs clear asynchronously.
  - key_pulse=4'b0001 on the first edge after reset.
- Build with KEY_REPEAT_EN undefined, hold key_n[0] for 20 cycles -> exactly one key_pulse, one key_rel on release, rpt_active always 0.
